// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback (WB) and the multi-cycle mul/div unit (MDU). MDU results go into a
// small FIFO and drain into WB slots that are idle. If the FIFO head waits
// STARVE_MAX cycles it takes the port anyway. When that happens the WB request
// is refused (wb_hold) and the pipeline replays it.
// The block also raises an ID interlock when the instruction in ID names a
// register that is still waiting in the FIFO.
//
// Ports
//   clk, rst_b           clock; synchronous active-low reset
//   halted               freezes the arbiter (no push, no pop, no write)
//   wb_we/wb_rd/wb_data  pipeline writeback request
//   mdu_valid/mdu_rd/mdu_data, mdu_ready
//                        MDU result handshake (transfer = valid & ready)
//   id_rs/id_rt/id_rd    register fields of the instruction in ID
//   rd_we/rd_num/rd_data register-file write port
//   wb_hold              WB write not taken this cycle; pipeline replays it
//   id_raw_stall         ID touches a register still pending in the FIFO
//   pend_count           number of valid FIFO entries
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int PTR_W      = 1,
  parameter int CNT_W      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             halted,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  input  logic             mdu_valid,
  input  logic [4:0]       mdu_rd,
  input  logic [31:0]      mdu_data,
  output logic             mdu_ready,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  output logic             rd_we,
  output logic [4:0]       rd_num,
  output logic [31:0]      rd_data,
  output logic             wb_hold,
  output logic             id_raw_stall,
  output logic [CNT_W-1:0] pend_count
);

  localparam int ST_W = $clog2(STARVE_MAX + 1);

  // A pending entry blocks ID when its destination equals any nonzero ID field.
  function automatic logic rd_hit(input logic [4:0] ent_rd,
                                  input logic [4:0] rs,
                                  input logic [4:0] rt,
                                  input logic [4:0] rdst);
    logic hit;
    hit = 1'b0;
    if ((rs != 5'd0) && (rs == ent_rd)) begin
      hit = 1'b1;
    end else if ((rt != 5'd0) && (rt == ent_rd)) begin
      hit = 1'b1;
    end else if ((rdst != 5'd0) && (rdst == ent_rd)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // FIFO storage and control state
  logic [4:0]       ent_rd_q   [DEPTH];
  logic [4:0]       ent_rd_d   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ST_W-1:0]  starve_q, starve_d;

  // Per-cycle decisions
  logic wb_busy_s;
  logic nonempty_s;
  logic force_s;
  logic pop_s;
  logic push_s;
  logic ready_s;

  // Arbitration decisions: who owns the write port, and whether the MDU may push.
  always_comb begin
    wb_busy_s  = wb_we & (wb_rd != 5'd0) & ~halted;
    nonempty_s = (count_q != {CNT_W{1'b0}});
    force_s    = nonempty_s & (starve_q == ST_W'(STARVE_MAX));
    pop_s      = nonempty_s & ~halted & (~wb_busy_s | force_s);
    // Readiness uses registered occupancy only; a full FIFO never accepts even if it pops.
    ready_s    = (count_q < CNT_W'(DEPTH)) & ~halted;
    // A result for r0 completes the handshake but allocates nothing.
    push_s     = mdu_valid & ready_s & (mdu_rd != 5'd0);
  end

  // Write-port mux: FIFO head on a pop, else the pipeline WB, else idle zeros.
  always_comb begin
    rd_we   = 1'b0;
    rd_num  = 5'd0;
    rd_data = 32'd0;
    if (pop_s) begin
      rd_we   = 1'b1;
      rd_num  = ent_rd_q[rd_ptr_q];
      rd_data = ent_data_q[rd_ptr_q];
    end else if (wb_busy_s) begin
      rd_we   = 1'b1;
      rd_num  = wb_rd;
      rd_data = wb_data;
    end else begin
      rd_we   = 1'b0;
      rd_num  = 5'd0;
      rd_data = 32'd0;
    end
    wb_hold    = wb_busy_s & force_s;
    mdu_ready  = ready_s;
    pend_count = count_q;
  end

  // Interlock: scan the registered contents, so an entry popped this cycle still blocks ID.
  always_comb begin
    logic [PTR_W-1:0] offset;
    id_raw_stall = 1'b0;
    offset       = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      // Distance from the head decides whether slot i holds a live entry.
      offset = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(offset) < count_q) && rd_hit(ent_rd_q[i], id_rs, id_rt, id_rd)) begin
        id_raw_stall = 1'b1;
      end else begin
        id_raw_stall = id_raw_stall;
      end
    end
  end

  // Next state for FIFO storage, pointers, occupancy and starvation counter.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd_d[i]   = ent_rd_q[i];
      ent_data_d[i] = ent_data_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (push_s) begin
      ent_rd_d[wr_ptr_q]   = mdu_rd;
      ent_data_d[wr_ptr_q] = mdu_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // The counter measures how long the current head has waited; it saturates so force holds.
    if (pop_s || !nonempty_s) begin
      starve_d = {ST_W{1'b0}};
    end else if (!halted && (starve_q != ST_W'(STARVE_MAX))) begin
      starve_d = starve_q + ST_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers with synchronous active-low reset that discards buffered results.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= 5'd0;
        ent_data_q[i] <= 32'd0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      starve_q <= {ST_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= ent_rd_d[i];
        ent_data_q[i] <= ent_data_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a queue-based reference model predicts every
// cycle's outputs. The expectations go into a scoreboard queue, and a monitor
// compares them on the falling edge.
module tb_wb_port_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst_b;
  logic        halted;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        rd_we;
  logic [4:0]  rd_num;
  logic [31:0] rd_data;
  logic        wb_hold;
  logic        id_raw_stall;
  logic [1:0]  pend_count;

  wb_port_arbiter #(.DEPTH(DEPTH), .PTR_W(1), .CNT_W(2), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .rd_we(rd_we), .rd_num(rd_num), .rd_data(rd_data),
    .wb_hold(wb_hold), .id_raw_stall(id_raw_stall), .pend_count(pend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        we;
    logic [4:0]  num;
    logic [31:0] data;
    logic        hold;
    logic        stall;
    logic [1:0]  cnt;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  exp_t exp_q[$];
  ent_t mq[$];
  int   starve_m;
  int   n_pass;
  int   n_total;
  int   cyc;
  bit   chk_en;

  // Monitor: one expectation per checked cycle, compared away from the active edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{ready: mdu_ready, we: rd_we, num: rd_num, data: rd_data,
               hold: wb_hold, stall: id_raw_stall, cnt: pend_count};
        n_total++;
        if (a !== e) begin
          $display("FAIL outputs t=%0t got rdy=%b we=%b num=%0d data=%h hold=%b stall=%b cnt=%0d want rdy=%b we=%b num=%0d data=%h hold=%b stall=%b cnt=%0d",
                   $time, a.ready, a.we, a.num, a.data, a.hold, a.stall, a.cnt,
                   e.ready, e.we, e.num, e.data, e.hold, e.stall, e.cnt);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // One clock cycle: drive inputs, predict the outputs from the model, advance the model.
  task automatic step(input logic r, input logic h,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ird);
    exp_t e;
    bit   busy, ne, frc, pop, acc;
    ent_t n;
    rst_b = r; halted = h; wb_we = we; wb_rd = wrd; wb_data = wd;
    mvalid_set(mv, mrd, md);
    id_rs = rs; id_rt = rt; id_rd = ird;

    busy = we && (wrd != 5'd0) && !h;
    ne   = (mq.size() != 0);
    frc  = ne && (starve_m == STARVE_MAX);
    pop  = ne && !h && (!busy || frc);
    e.ready = (mq.size() < DEPTH) && !h;
    e.we    = pop || busy;
    e.num   = pop ? mq[0].rd   : (busy ? wrd : 5'd0);
    e.data  = pop ? mq[0].data : (busy ? wd  : 32'd0);
    e.hold  = busy && frc;
    e.stall = 1'b0;
    foreach (mq[i]) begin
      if ((rs != 5'd0 && rs == mq[i].rd) || (rt != 5'd0 && rt == mq[i].rd) ||
          (ird != 5'd0 && ird == mq[i].rd)) e.stall = 1'b1;
    end
    e.cnt = 2'(mq.size());
    if (chk_en) exp_q.push_back(e);

    if (!r) begin
      mq.delete();
      starve_m = 0;
    end else begin
      acc = mv && e.ready;
      if (pop) void'(mq.pop_front());
      if (acc && mrd != 5'd0) begin
        n.rd = mrd; n.data = md;
        mq.push_back(n);
      end
      if (pop || !ne) starve_m = 0;
      else if (!h && starve_m < STARVE_MAX) starve_m++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mvalid_set(input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic busy_push(input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    step(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0333, mv, mrd, md, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    int phase;
    int pct;
    n_pass = 0; n_total = 0; cyc = 0; starve_m = 0; chk_en = 1'b0;
    rst_b = 1'b0; halted = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    @(posedge clk);
    #1;

    // 1) reset: first cycle unknown state, then checked while reset still asserted
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    idle(1);

    // 2) push into idle WB, written the next cycle
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234, 5'd0, 5'd0, 5'd0);
    idle(3);

    // 3) WB busy every cycle, one push: starvation forces the slot
    busy_push(1'b1, 5'd7, 32'h0000_0777);
    for (int k = 0; k < 8; k++) busy_push(1'b0, 5'd0, 32'd0);
    idle(2);

    // 4) fill the FIFO under busy WB; third result refused; in-order drain
    busy_push(1'b1, 5'd8, 32'h0000_0888);
    busy_push(1'b1, 5'd9, 32'h0000_0999);
    busy_push(1'b1, 5'd10, 32'h0000_0AAA);
    busy_push(1'b0, 5'd0, 32'd0);
    idle(4);

    // 5) interlock on a pending entry; r0 result dropped
    busy_push(1'b1, 5'd10, 32'h0000_1010);
    step(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0333, 1'b0, 5'd0, 32'd0, 5'd0, 5'd10, 5'd0);
    step(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd0, 32'hDEAD_0000, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0333, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd10);
    idle(3);

    // 6) halt with one entry, then release; reset with two entries
    busy_push(1'b1, 5'd12, 32'h0000_0C0C);
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0444, 1'b1, 5'd13, 32'h0000_0D0D, 5'd0, 5'd12, 5'd0);
    idle(2);
    busy_push(1'b1, 5'd14, 32'h0000_0E0E);
    busy_push(1'b1, 5'd15, 32'h0000_0F0F);
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    idle(3);

    // Random traffic with phases of light, medium and heavy WB load
    for (int i = 0; i < 3000; i++) begin
      phase = (i / 200) % 3;
      pct   = (phase == 0) ? 30 : ((phase == 1) ? 70 : 95);
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) < pct),
           5'($urandom_range(0, 31)),
           $urandom(),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 12)),
           $urandom(),
           5'($urandom_range(0, 12)),
           5'($urandom_range(0, 12)),
           5'($urandom_range(0, 12)));
    end
    idle(2);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
